// File: rtl/nios2core_syskey_ctrl_if.sv
// Avalon-MM slave bus bundle for the system-key controller.
// Latency: n/a (wires only).
// Backpressure: none; the bus carries no wait-request.
interface nios2core_syskey_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/nios2core_syskey_ctrl.sv
// Push-key synchroniser, tick-based debouncer and edge-capture interrupt controller.
// Latency: reads 1 cycle; key change reaches STATE 2 sync cycles + DEBOUNCE_COUNT ticks later.
// Backpressure: none; the slave accepts every access with no wait states.
module nios2core_syskey_ctrl #(
    parameter int KEY_WIDTH      = 3,
    parameter int TICK_DIV       = 50000,
    parameter int DEBOUNCE_COUNT = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    nios2core_syskey_ctrl_if.slave av,
    input  logic [KEY_WIDTH-1:0]   in_port,
    output logic                   irq
);
    localparam int              PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0]      DB_LAST   = 4'(DEBOUNCE_COUNT - 1);

    logic [KEY_WIDTH-1:0] sync1_q, sync1_d;
    logic [KEY_WIDTH-1:0] sync2_q, sync2_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [3:0]           cnt_q [KEY_WIDTH];
    logic [3:0]           cnt_d [KEY_WIDTH];
    logic [KEY_WIDTH-1:0] state_q, state_d;
    logic [KEY_WIDTH-1:0] mask_q, mask_d;
    logic [KEY_WIDTH-1:0] edge_q, edge_d;
    logic [KEY_WIDTH-1:0] sel_q, sel_d;
    logic                 irq_q, irq_d;
    logic [31:0]          rdata_q, rdata_d;

    logic                 tick;
    logic                 wr_en;
    logic [KEY_WIDTH-1:0] wr_dat;
    logic [KEY_WIDTH-1:0] event_vec;

    // High writedata bits are deliberately ignored when KEY_WIDTH < 32.
    logic unused_wdat;
    assign unused_wdat = ^av.writedata;

    assign wr_en  = av.chipselect & ~av.write_n;
    assign wr_dat = av.writedata[KEY_WIDTH-1:0];
    assign tick   = (presc_q == TICK_LAST);

    // Input synchroniser shift and free-running sample prescaler.
    always_comb begin
        sync1_d = in_port;
        sync2_d = sync1_q;
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    // Per-key debounce: count consecutive differing samples on each tick, flip at the limit.
    always_comb begin
        state_d   = state_q;
        event_vec = '0;
        for (int k = 0; k < KEY_WIDTH; k++) begin
            cnt_d[k] = cnt_q[k];
            if (tick) begin
                if (sync2_q[k] == state_q[k]) begin
                    cnt_d[k] = '0;
                end else if (cnt_q[k] == DB_LAST) begin
                    cnt_d[k]     = '0;
                    state_d[k]   = ~state_q[k];
                    // New level equal to EDGE_SEL means the selected direction occurred.
                    event_vec[k] = (state_q[k] != sel_q[k]);
                end else begin
                    cnt_d[k] = cnt_q[k] + 4'd1;
                end
            end
        end
    end

    // Register file writes, W1C edge capture (set beats clear), irq and read mux.
    always_comb begin
        mask_d  = mask_q;
        sel_d   = sel_q;
        edge_d  = edge_q;
        if (wr_en && av.address == 2'd1) mask_d = wr_dat;
        if (wr_en && av.address == 2'd3) sel_d  = wr_dat;
        if (wr_en && av.address == 2'd2) edge_d = edge_q & ~wr_dat;
        edge_d  = edge_d | event_vec;
        irq_d   = |(edge_q & mask_q);
        rdata_d = '0;
        case (av.address)
            2'd0:    rdata_d[KEY_WIDTH-1:0] = state_q;
            2'd1:    rdata_d[KEY_WIDTH-1:0] = mask_q;
            2'd2:    rdata_d[KEY_WIDTH-1:0] = edge_q;
            default: rdata_d[KEY_WIDTH-1:0] = sel_q;
        endcase
    end

    // State registers; keys idle high (released) out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
            presc_q <= '0;
            for (int k = 0; k < KEY_WIDTH; k++) cnt_q[k] <= '0;
            state_q <= '1;
            mask_q  <= '0;
            edge_q  <= '0;
            sel_q   <= '0;
            irq_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            presc_q <= presc_d;
            for (int k = 0; k < KEY_WIDTH; k++) cnt_q[k] <= cnt_d[k];
            state_q <= state_d;
            mask_q  <= mask_d;
            edge_q  <= edge_d;
            sel_q   <= sel_d;
            irq_q   <= irq_d;
            rdata_q <= rdata_d;
        end
    end

    assign av.readdata = rdata_q;
    assign irq         = irq_q;
endmodule

// File: tb/tb_nios2core_syskey_ctrl.sv
module tb_nios2core_syskey_ctrl;
    localparam int TD = 4;
    localparam int DC = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] keys = 3'b111;
    logic       irq;
    int         n_checks = 0;
    int         n_pass = 0;

    nios2core_syskey_ctrl_if bus();

    nios2core_syskey_ctrl #(.KEY_WIDTH(3), .TICK_DIV(TD), .DEBOUNCE_COUNT(DC)) dut (
        .clk(clk), .reset_n(reset_n), .av(bus), .in_port(keys), .irq(irq)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // Sample ticks fall every TD-th cycle since reset; a key flips after DC
    // consecutive tick samples that disagree with its clean level.
    int unsigned m_cyc;
    logic [2:0]  m_s1, m_s2, m_state, m_mask, m_edge, m_sel;
    int          m_run [3];
    logic [31:0] m_rd;
    logic        m_irq;

    task automatic model_reset();
        m_cyc = 0; m_s1 = 3'b111; m_s2 = 3'b111; m_state = 3'b111;
        m_mask = 0; m_edge = 0; m_sel = 0; m_rd = 0; m_irq = 0;
        for (int k = 0; k < 3; k++) m_run[k] = 0;
    endtask

    task automatic model_edge();
        logic [2:0] ns, ev, ne;
        m_rd = 0;
        case (bus.address)
            2'd0: m_rd[2:0] = m_state;
            2'd1: m_rd[2:0] = m_mask;
            2'd2: m_rd[2:0] = m_edge;
            default: m_rd[2:0] = m_sel;
        endcase
        m_irq = |(m_edge & m_mask);
        ns = m_state; ev = 0;
        if (m_cyc % TD == TD - 1) begin
            for (int k = 0; k < 3; k++) begin
                if (m_s2[k] == m_state[k]) m_run[k] = 0;
                else begin
                    m_run[k]++;
                    if (m_run[k] == DC) begin
                        ns[k] = ~m_state[k];
                        m_run[k] = 0;
                        ev[k] = (ns[k] == m_sel[k]);
                    end
                end
            end
        end
        ne = m_edge;
        if (bus.chipselect && !bus.write_n) begin
            case (bus.address)
                2'd1: m_mask = bus.writedata[2:0];
                2'd2: ne = m_edge & ~bus.writedata[2:0];
                2'd3: m_sel = bus.writedata[2:0];
                default: ;
            endcase
        end
        m_edge = ne | ev;
        m_state = ns;
        m_s2 = m_s1;
        m_s1 = keys;
        m_cyc++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_edge();
        end
    end

    // True when the coming clock edge will flip key0's clean level.
    function automatic logic key0_flips_next();
        return (m_cyc % TD == TD - 1) && (m_s2[0] != m_state[0]) && (m_run[0] == DC - 1);
    endfunction

    // ---------------- bus helpers (called at a falling edge) ----------------
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus.address = a;
        @(negedge clk);
        d = bus.readdata;
    endtask

    // Advance n cycles comparing readdata and irq with the model every cycle.
    task automatic run_cmp(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.readdata !== m_rd || irq !== m_irq)
                $display("FAIL %s cyc%0d rd=%h irq=%b exp rd=%h irq=%b", tag, i, bus.readdata, irq, m_rd, m_irq);
            else n_pass++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] rd;
        logic [31:0] exp_rd [4];
        exp_rd[0] = 32'h7; exp_rd[1] = 0; exp_rd[2] = 0; exp_rd[3] = 0;
        reset_n = 1'b0;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        n_checks++;
        if (bus.readdata !== 32'h0 || irq !== 1'b0)
            $display("FAIL reset_out rd=%h irq=%b exp rd=0 irq=0", bus.readdata, irq);
        else n_pass++;
        for (int a = 0; a < 4; a++) begin
            bus_read(a[1:0], rd);
            n_checks++;
            if (rd !== exp_rd[a]) $display("FAIL reset_reg%0d got=%h exp=%h", a, rd, exp_rd[a]);
            else n_pass++;
        end
    endtask

    task automatic test_clean_press();
        logic [31:0] rd;
        int found = 0;
        bus_write(2'd1, 32'h1);
        bus.address = 2'd0;
        keys = 3'b110;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.readdata !== m_rd || irq !== m_irq)
                $display("FAIL press_track cyc%0d rd=%h irq=%b exp rd=%h irq=%b", i, bus.readdata, irq, m_rd, m_irq);
            else n_pass++;
            if (found == 0 && bus.readdata[2:0] == 3'b110) begin
                found = i;
                n_checks++;
                if (irq !== 1'b1) $display("FAIL press_irq got=%b exp=1", irq);
                else n_pass++;
            end
        end
        n_checks++;
        if (found == 0 || found > 15) $display("FAIL press_latency got=%0d exp=1..15", found);
        else n_pass++;
        bus_read(2'd2, rd);
        n_checks++;
        if (rd !== 32'h1) $display("FAIL press_edge got=%h exp=1", rd);
        else n_pass++;
    endtask

    task automatic test_bounce();
        logic [31:0] rd;
        bus_write(2'd2, 32'h7);
        bus.address = 2'd0;
        run_cmp(2, "bounce_clr");
        for (int c = 0; c < 40; c++) begin
            if (c % 3 == 0) keys[1] = ~keys[1];
            @(negedge clk);
            n_checks++;
            if (bus.readdata[1] !== 1'b1 || irq !== 1'b0 || bus.readdata !== m_rd)
                $display("FAIL bounce_cyc%0d rd=%h irq=%b exp rd=%h irq=0", c, bus.readdata, irq, m_rd);
            else n_pass++;
        end
        keys[1] = 1'b1;
        run_cmp(20, "bounce_settle");
        bus_read(2'd0, rd);
        n_checks++;
        if (rd !== 32'h6) $display("FAIL bounce_state got=%h exp=6", rd);
        else n_pass++;
        bus_read(2'd2, rd);
        n_checks++;
        if (rd !== 32'h0 || irq !== 1'b0) $display("FAIL bounce_edge got=%h irq=%b exp=0 irq=0", rd, irq);
        else n_pass++;
    endtask

    task automatic test_release_select();
        logic [31:0] rd;
        bus_write(2'd3, 32'h4);
        bus_write(2'd1, 32'h4);
        keys[2] = 1'b0;
        run_cmp(20, "rel_press");
        bus_read(2'd2, rd);
        n_checks++;
        if (rd !== 32'h0) $display("FAIL rel_press_edge got=%h exp=0", rd);
        else n_pass++;
        keys[2] = 1'b1;
        run_cmp(20, "rel_release");
        bus_read(2'd2, rd);
        n_checks++;
        if (rd !== 32'h4 || irq !== 1'b1) $display("FAIL rel_edge got=%h irq=%b exp=4 irq=1", rd, irq);
        else n_pass++;
        bus_write(2'd2, 32'h4);
        n_checks++;
        if (irq !== 1'b1) $display("FAIL rel_irq_hold got=%b exp=1", irq);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (irq !== 1'b0) $display("FAIL rel_irq_drop got=%b exp=0", irq);
        else n_pass++;
        bus_read(2'd2, rd);
        n_checks++;
        if (rd !== 32'h0) $display("FAIL rel_w1c got=%h exp=0", rd);
        else n_pass++;
    endtask

    task automatic test_collision();
        logic [31:0] rd;
        logic hit = 1'b0;
        keys[0] = 1'b1;
        bus.address = 2'd0;
        run_cmp(20, "col_release");
        bus_write(2'd1, 32'h1);
        keys[0] = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (key0_flips_next()) begin
                bus_write(2'd2, 32'h1);
                hit = 1'b1;
            end else @(negedge clk);
        end
        n_checks++;
        if (!hit) $display("FAIL col_timeout flip not reached got=0 exp=1");
        else n_pass++;
        bus_read(2'd2, rd);
        n_checks++;
        if (rd !== 32'h1) $display("FAIL col_set_wins got=%h exp=1", rd);
        else n_pass++;
        bus_write(2'd2, 32'h1);
        bus_read(2'd2, rd);
        n_checks++;
        if (rd !== 32'h0) $display("FAIL col_plain_w1c got=%h exp=0", rd);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int flip_at = 0;
        int waited = 0;
        keys[0] = 1'b1;
        bus.address = 2'd0;
        run_cmp(20, "mid_release");
        keys[0] = 1'b0;
        while (m_run[0] != 2 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (m_run[0] != 2) $display("FAIL mid_two_ticks timeout got=%0d exp=2", m_run[0]);
        else n_pass++;
        reset_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.readdata !== 32'h0 || irq !== 1'b0)
            $display("FAIL mid_reset_out rd=%h irq=%b exp rd=0 irq=0", bus.readdata, irq);
        else n_pass++;
        reset_n = 1'b1;
        bus_read(2'd0, rd);
        n_checks++;
        if (rd !== 32'h7) $display("FAIL mid_state got=%h exp=7", rd);
        else n_pass++;
        for (int i = 1; i <= 20 && flip_at == 0; i++) begin
            @(negedge clk);
            if (bus.readdata[2:0] == 3'b110) flip_at = i;
        end
        n_checks++;
        if (flip_at != 12) $display("FAIL mid_full_debounce got=%0d exp=12", flip_at);
        else n_pass++;
        bus_read(2'd2, rd);
        n_checks++;
        if (rd !== 32'h1) $display("FAIL mid_edge got=%h exp=1", rd);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 60; it++) begin
            int hold;
            keys = 3'($urandom);
            hold = $urandom_range(1, 24);
            for (int h = 0; h < hold; h++) begin
                bus.address = 2'($urandom);
                bus.writedata = $urandom;
                if ($urandom_range(0, 7) == 0) begin
                    bus.chipselect = 1'b1; bus.write_n = 1'b0;
                end else begin
                    bus.chipselect = 1'($urandom); bus.write_n = 1'b1;
                end
                @(negedge clk);
                n_checks++;
                if (bus.readdata !== m_rd || irq !== m_irq)
                    $display("FAIL random it%0d rd=%h irq=%b exp rd=%h irq=%b", it, bus.readdata, irq, m_rd, m_irq);
                else n_pass++;
            end
        end
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    initial begin
        bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'h0;
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_select();
        test_collision();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/nios2core_syskey_ctrl.md
# nios2core_syskey_ctrl

Debounce and event controller for the three system push-keys on the Nios II core's Avalon-MM peripheral bus. It synchronises the raw key inputs and debounces them with a shared sample-tick prescaler. It captures press or release edges per key and raises a maskable interrupt, so software polls nothing and reads clean key state.

## Interface
- `KEY_WIDTH`, default 3: number of keys, 1..32.
- `TICK_DIV`, default 50000: sample-tick period in `clk` cycles, ≥2.
- `DEBOUNCE_COUNT`, default 4: consecutive differing samples needed to flip a key, 1..15.

- `clk`  in  1  system clock. Single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  2  register word select.
- `chipselect`  in  1  Avalon slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data.
- `in_port`  in  KEY_WIDTH  raw key inputs, asynchronous, active-low (0 = pressed).
- `irq`  out  1  level interrupt, active-high.

## Operation
- Register map, word addresses:
  - 0 STATE (RO): debounced key levels in [KEY_WIDTH-1:0]. Writes are ignored.
  - 1 IRQ_MASK (RW): a 1 enables the edge bit of that key onto `irq`.
  - 2 EDGE_CAPTURE (R/W1C): sticky event bits. Writing 1 clears a bit; writing 0 leaves it unchanged.
  - 3 EDGE_SEL (RW): per key, 0 captures a press (1→0), 1 captures a release (0→1).
  - Unused high bits read 0.
- A write occurs when `chipselect` = 1 and `write_n` = 0. Only bits [KEY_WIDTH-1:0] are used.
- Synchroniser: two flops per key on `in_port`. Both reset to all ones.
- Prescaler:
  - The counter runs 0..TICK_DIV-1 and wraps.
  - `tick` is a one-cycle pulse when the count equals TICK_DIV-1.
  - The counter is free-running and reset to 0.
- Per-key debounce, evaluated only on `tick`:
  - Synced sample equals the debounced level: the counter clears to 0.
  - Sample differs: the counter increments. When the incremented value equals DEBOUNCE_COUNT, the debounced level flips and the counter clears.
  - Debounced levels reset to all ones. Counters are 4 bits and reset to 0.
- Edge capture:
  - On the cycle a debounced level flips in the direction selected by EDGE_SEL, that EDGE_CAPTURE bit sets.
  - If a set and a W1C clear hit the same bit in the same cycle, the set wins.
  - A flip in the non-selected direction sets nothing.
- `irq` is a register loaded each cycle with OR(EDGE_CAPTURE & IRQ_MASK). Clearing the mask or the edge bit drops `irq` one cycle later.
- Changing EDGE_SEL does not alter existing capture bits.

## Timing
- Reset values:
  - `readdata` = 0, `irq` = 0.
  - IRQ_MASK = 0, EDGE_CAPTURE = 0, EDGE_SEL = 0.
  - STATE = all ones, prescaler = 0, debounce counters = 0.
- Read latency is one cycle. `readdata` is registered every cycle from the `address` mux, independent of `chipselect`, with no wait states.
- A write takes effect on the clock edge where it is presented. A read in the next cycle returns the new value.
- Input to STATE latency: 2 synchroniser cycles, then DEBOUNCE_COUNT ticks. The flip lands on the cycle the DEBOUNCE_COUNT-th qualifying `tick` is asserted.
- EDGE_CAPTURE sets in the same cycle as the STATE flip. `irq` follows 1 cycle later.
- A glitch shorter than one tick period may be missed or may reset the count. Any sample that matches the debounced level restarts the count.
- Reset asserted mid-debounce aborts the debounce immediately, with no pending event retained.

## Test plan
Use TICK_DIV = 4 and DEBOUNCE_COUNT = 3 for all scenarios.
- Reset: read addresses 0..3 → 0x7, 0x0, 0x0, 0x0. `irq` = 0.
- Clean press: key0 driven 0 and held. STATE reads 0x6 within 2 + 3×4 cycles. With IRQ_MASK = 0x1, EDGE_CAPTURE = 0x1 and `irq` = 1 one cycle after the flip.
- Bounce: key1 toggled every 3 cycles for 40 cycles, then held 1. STATE bit1 stays 1, EDGE_CAPTURE stays 0, no `irq`.
- Release select: EDGE_SEL = 0x4, then key2 pressed and released.
  - The press sets no bit.
  - The release sets EDGE_CAPTURE = 0x4.
  - Writing 0x4 to address 2 clears it and drops `irq` one cycle later.
- Collision: time a W1C of bit0 on the exact cycle a new key0 press flips STATE. Bit0 must remain 1.
- Reset mid-debounce: pulse `reset_n` after 2 qualifying ticks of a press. STATE = 0x7 and counters are 0. A held press then needs the full 3 ticks again.
